// File: rtl/refri_dispatch_ctrl.sv
// rtl/refri_dispatch_ctrl.sv - refrigerator vend dispatch controller
// Queues {D1,T} vend events from the coin FSM and runs motor / coin-eject handshakes in order.
module refri_dispatch_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     D1,
    input  logic [1:0]               T,
    output logic                     motor_on,
    input  logic                     motor_done,
    output logic                     coin_req,
    input  logic                     coin_ack,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     ovf,
    output logic                     fault
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] DEPTH_C   = PW'(DEPTH);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_DISP,
        S_CHANGE,
        S_FAULT
    } state_t;

    logic [2:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [PW-1:0] r_count;
    logic          r_ovf;

    state_t        r_state;
    logic [2:0]    r_coins;
    logic [WW-1:0] r_wait;
    logic          r_motor_on;
    logic          r_coin_req;
    logic          r_fault;

    logic          w_event;
    logic          w_pop;
    logic          w_full;
    logic          w_push;
    logic [2:0]    w_head;
    logic [2:0]    w_coins_load;

    assign w_event = D1 | (T != 2'b00);
    assign w_pop   = (r_state == S_POP);
    assign w_full  = (r_count == DEPTH_C);
    // A full queue still accepts an event in the cycle its head is being popped.
    assign w_push  = w_event && (!w_full || w_pop);
    assign w_head  = r_mem[r_rptr];

    always_comb begin
        w_coins_load = 3'd0;
        case (w_head[1:0])
            2'b01:   w_coins_load = 3'd1;
            2'b10:   w_coins_load = 3'd2;
            2'b11:   w_coins_load = 3'd4;
            default: w_coins_load = 3'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {D1, T};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_event && !w_push) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_coins    <= 3'd0;
            r_wait     <= '0;
            r_motor_on <= 1'b0;
            r_coin_req <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_count != '0) begin
                        r_state <= S_POP;
                    end
                end
                S_POP: begin
                    r_coins <= w_coins_load;
                    r_wait  <= '0;
                    if (w_head[2]) begin
                        r_state    <= S_DISP;
                        r_motor_on <= 1'b1;
                    end else if (w_head[1:0] != 2'b00) begin
                        r_state    <= S_CHANGE;
                        r_coin_req <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_DISP: begin
                    if (motor_done) begin
                        r_motor_on <= 1'b0;
                        r_wait     <= '0;
                        if (r_coins != 3'd0) begin
                            r_state    <= S_CHANGE;
                            r_coin_req <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (r_wait == WAIT_LAST) begin
                        r_state    <= S_FAULT;
                        r_motor_on <= 1'b0;
                        r_fault    <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_CHANGE: begin
                    // Each ack restarts the timeout window for the next coin.
                    if (coin_ack) begin
                        r_wait  <= '0;
                        r_coins <= r_coins - 3'd1;
                        if (r_coins <= 3'd1) begin
                            r_state    <= S_IDLE;
                            r_coin_req <= 1'b0;
                        end
                    end else if (r_wait == WAIT_LAST) begin
                        r_state    <= S_FAULT;
                        r_coin_req <= 1'b0;
                        r_fault    <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_FAULT: begin
                    r_motor_on <= 1'b0;
                    r_coin_req <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign motor_on = r_motor_on;
    assign coin_req = r_coin_req;
    assign busy     = (r_state != S_IDLE) || (r_count != '0);
    assign pending  = r_count;
    assign ovf      = r_ovf;
    assign fault    = r_fault;

endmodule

// File: tb/tb_refri_dispatch_ctrl.sv
// tb/tb_refri_dispatch_ctrl.sv - self-checking bench for refri_dispatch_ctrl
module tb_refri_dispatch_ctrl;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;
    localparam byte K_M = 8'd1;
    localparam byte K_C = 8'd2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       D1 = 1'b0;
    logic [1:0] T = 2'b00;
    logic       motor_done = 1'b0;
    logic       coin_ack = 1'b0;
    logic       motor_on;
    logic       coin_req;
    logic       busy;
    logic [2:0] pending;
    logic       ovf;
    logic       fault;

    always #5 clk = ~clk;

    refri_dispatch_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .D1         (D1),
        .T          (T),
        .motor_on   (motor_on),
        .motor_done (motor_done),
        .coin_req   (coin_req),
        .coin_ack   (coin_ack),
        .busy       (busy),
        .pending    (pending),
        .ovf        (ovf),
        .fault      (fault)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    byte sb_q[$];

    task automatic sb_check(input byte kind);
        byte e;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got kind %0d expected none", kind);
        end else begin
            e = sb_q.pop_front();
            if (e != kind) begin
                n_fail++;
                $display("FAIL sb_order: got kind %0d expected %0d", kind, e);
            end
        end
    endtask

    // Responder and monitor: handshakes are scored at the negedge after the DUT sampled them.
    int   md_delay  = 0;
    int   ack_gap   = 1;
    logic force_ack = 1'b0;
    int   mcnt = 0, ccnt = 0;
    int   mo_cycles = 0, cr_cycles = 0, both_hi = 0, coin_hs = 0, motor_hs = 0;
    logic last_mo = 1'b0, last_cr = 1'b0;

    always @(negedge clk) begin
        if (motor_done && last_mo) begin
            motor_hs++;
            sb_check(K_M);
        end
        if (coin_ack && last_cr) begin
            coin_hs++;
            sb_check(K_C);
        end
        if (motor_on) mo_cycles++;
        if (coin_req) cr_cycles++;
        if (motor_on && coin_req) both_hi++;
        last_mo = motor_on;
        last_cr = coin_req;
        if (motor_on) mcnt++; else mcnt = 0;
        motor_done = motor_on && (mcnt == md_delay);
        if (coin_req) ccnt++; else ccnt = 0;
        coin_ack = force_ack || (coin_req && (ccnt == ack_gap));
        if (coin_ack) ccnt = 0;
    end

    typedef struct {
        logic       d1;
        logic [1:0] t;
        int         md;
        int         gap;
        logic       fack;
        int         exp_mo;
        int         exp_coins;
    } vec_t;

    vec_t vecs[7];
    int   lat, cyc, hs0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 2'b00, 5, 1, 1'b0, 5, 0};
        vecs[1] = '{1'b1, 2'b01, 3, 1, 1'b0, 3, 1};
        vecs[2] = '{1'b0, 2'b10, 0, 1, 1'b0, 0, 2};
        vecs[3] = '{1'b0, 2'b11, 0, 2, 1'b0, 0, 4};
        vecs[4] = '{1'b1, 2'b10, 2, 3, 1'b0, 2, 2};
        vecs[5] = '{1'b1, 2'b10, 4, 1, 1'b1, 4, 2};
        vecs[6] = '{1'b1, 2'b11, 7, 1, 1'b0, 7, 4};

        repeat (3) @(negedge clk);
        check("rst_motor_on", motor_on, 0);
        check("rst_coin_req", coin_req, 0);
        check("rst_busy", busy, 0);
        check("rst_pending", pending, 0);
        check("rst_ovf", ovf, 0);
        check("rst_fault", fault, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            md_delay  = vecs[i].md;
            ack_gap   = vecs[i].gap;
            force_ack = vecs[i].fack;
            mo_cycles = 0;
            cr_cycles = 0;
            if (vecs[i].d1) sb_q.push_back(K_M);
            for (int c = 0; c < vecs[i].exp_coins; c++) sb_q.push_back(K_C);
            D1 = vecs[i].d1;
            T  = vecs[i].t;
            @(negedge clk);
            D1 = 1'b0;
            T  = 2'b00;
            check($sformatf("v%0d_pend_push", i), pending, 1);
            lat = 1;
            if (vecs[i].d1) begin
                while (!motor_on && lat < 10) begin
                    @(negedge clk);
                    lat++;
                end
                check($sformatf("v%0d_latency", i), lat, 3);
            end
            cyc = 0;
            while (busy && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            force_ack = 1'b0;
            check($sformatf("v%0d_idle", i), busy, 0);
            check($sformatf("v%0d_motor_cycles", i), mo_cycles, vecs[i].exp_mo);
            check($sformatf("v%0d_coin_cycles", i), cr_cycles, vecs[i].exp_coins * vecs[i].gap);
            check($sformatf("v%0d_pend_end", i), pending, 0);
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("sb_drain_table", sb_q.size(), 0);

        // Overflow: five events arrive while a plain dispense holds the motor.
        md_delay = 7;
        ack_gap  = 1;
        mo_cycles = 0;
        cr_cycles = 0;
        sb_q.push_back(K_M);
        for (int k = 0; k < 4; k++) begin
            sb_q.push_back(K_M);
            for (int c = 0; c < 4; c++) sb_q.push_back(K_C);
        end
        D1 = 1'b1;
        T  = 2'b00;
        @(negedge clk);
        D1 = 1'b0;
        cyc = 0;
        while (!motor_on && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("ovf_motor_started", motor_on, 1);
        for (int k = 0; k < 5; k++) begin
            D1 = 1'b1;
            T  = 2'b11;
            @(negedge clk);
        end
        D1 = 1'b0;
        T  = 2'b00;
        check("ovf_pending_sat", pending, 4);
        check("ovf_flag", ovf, 1);
        cyc = 0;
        while (busy && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("ovf_idle", busy, 0);
        check("ovf_motor_cycles", mo_cycles, 35);
        check("ovf_coin_cycles", cr_cycles, 16);
        check("ovf_sticky", ovf, 1);
        repeat (2) @(negedge clk);
        check("sb_drain_ovf", sb_q.size(), 0);

        // Reset mid-change with two coins left and two events queued.
        rst = 1'b1;
        #1;
        check("rst2_ovf_clear", ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        ack_gap = 3;
        for (int k = 0; k < 12; k++) sb_q.push_back(K_C);
        hs0 = coin_hs;
        for (int k = 0; k < 3; k++) begin
            D1 = 1'b0;
            T  = 2'b11;
            @(negedge clk);
        end
        T = 2'b00;
        cyc = 0;
        while (coin_hs < hs0 + 2 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_acks", coin_hs - hs0, 2);
        check("mid_pending", pending, 2);
        check("mid_coin_req", coin_req, 1);
        rst = 1'b1;
        #1;
        check("async_coin_req", coin_req, 0);
        check("async_pending", pending, 0);
        check("async_busy", busy, 0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        cr_cycles = 0;
        mo_cycles = 0;
        repeat (30) @(negedge clk);
        check("post_rst_coin_cycles", cr_cycles, 0);
        check("post_rst_busy", busy, 0);

        // Motor never completes: timeout into FAULT, queue keeps accepting.
        md_delay = 0;
        ack_gap  = 1;
        mo_cycles = 0;
        D1 = 1'b1;
        @(negedge clk);
        D1 = 1'b0;
        cyc = 0;
        while (!fault && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("to_fault", fault, 1);
        check("to_motor_off", motor_on, 0);
        check("to_motor_cycles", mo_cycles, TIMEOUT);
        for (int k = 0; k < 2; k++) begin
            D1 = 1'b1;
            T  = 2'b01;
            @(negedge clk);
        end
        D1 = 1'b0;
        T  = 2'b00;
        check("fault_pending2", pending, 2);
        repeat (10) @(negedge clk);
        check("fault_no_pop", pending, 2);
        check("fault_busy", busy, 1);
        check("fault_coin_req", coin_req, 0);
        check("fault_motor_on", motor_on, 0);
        for (int k = 0; k < 3; k++) begin
            D1 = 1'b1;
            @(negedge clk);
        end
        D1 = 1'b0;
        check("fault_pending_sat", pending, 4);
        check("fault_ovf", ovf, 1);
        check("fault_sticky", fault, 1);

        check("never_both_high", both_hi, 0);
        check("sb_final", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
